// File: rtl/xillybus_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xillybus_mem_pkg
// Description : Shared constants and helpers for the Xillybus seekable
//               memory bridge. Holds the end-of-memory mode encodings and
//               the depth helper used to size the RAM and pointers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package xillybus_mem_pkg;

  // End-of-memory behaviour selected by the bridge's WRAP parameter.
  localparam int MEM_MODE_STOP = 0;  // pointers stop at DEPTH, flags raise
  localparam int MEM_MODE_WRAP = 1;  // pointers roll over DEPTH-1 -> 0

  // Number of RAM words addressed by an addr_w-bit address.
  function automatic int unsigned mem_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xillybus_mem_dpram.sv
`default_nettype none
// ============================================================================
// Module      : xillybus_mem_dpram
// Description : Synchronous read-first RAM. Port A carries the stream write
//               and stream read; port B is a free-running read used by peer
//               hardware. Reads return the contents from before any write on
//               the same edge. Storage is never reset so it maps onto block
//               or distributed RAM; only the read-data registers reset.
// Ports       : clk, rst_n          - clock, async active-low reset
//               wr_en/wr_addr/wr_data - port A write
//               rd_en/rd_addr/rd_data - port A read, 1-cycle latency, holds
//               b_addr/b_data         - port B read, 1-cycle latency, always
// Revision    : 1.0 - initial release
// ============================================================================
module xillybus_mem_dpram
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  localparam int unsigned c_depth = mem_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [0:c_depth-1];

  // Storage: no reset, so contents survive a bridge reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Output registers. Non-blocking reads of r_mem see the pre-write
  // contents, which gives read-first behaviour on both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      b_data  <= '0;
    end else begin
      if (rd_en) begin
        rd_data <= r_mem[rd_addr];
      end
      b_data <= r_mem[b_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/xillybus_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : xillybus_mem_bridge
// Description : Terminates a Xillybus seekable address/data pipe pair into an
//               on-chip RAM, with a registered side read port for peer logic.
//               Write and read pointers are ADDR_W+1 bits; in wrap mode they
//               roll over and the top bit stays 0, in stop mode they park at
//               DEPTH and raise full / empty / eof.
// Ports       : bus_clk, bus_rst_n          - clock, async active-low reset
//               user_w_mem_wren/data/full/open - stream write side
//               user_r_mem_rden/data/empty/eof/open - stream read side
//               user_mem_addr, user_mem_addr_update - seek
//               hw_rd_addr, hw_rd_data       - side read port, 1-cycle latency
//               mem_wr_strobe                - pulse one cycle after a write
// Revision    : 1.0 - initial release
// ============================================================================
module xillybus_mem_bridge
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int WRAP   = 1
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              user_w_mem_wren,
  input  logic [DATA_W-1:0] user_w_mem_data,
  output logic              user_w_mem_full,
  input  logic              user_w_mem_open,
  input  logic              user_r_mem_rden,
  output logic [DATA_W-1:0] user_r_mem_data,
  output logic              user_r_mem_empty,
  output logic              user_r_mem_eof,
  input  logic              user_r_mem_open,
  input  logic [ADDR_W-1:0] user_mem_addr,
  input  logic              user_mem_addr_update,
  input  logic [ADDR_W-1:0] hw_rd_addr,
  output logic [DATA_W-1:0] hw_rd_data,
  output logic              mem_wr_strobe
);

  localparam int unsigned     c_depth    = mem_depth(ADDR_W);
  localparam logic [ADDR_W:0] c_ptr_end  = (ADDR_W+1)'(c_depth);
  localparam logic [ADDR_W:0] c_one_p    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_one_a  = ADDR_W'(1);
  localparam logic            c_stop     = (WRAP == MEM_MODE_STOP);

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_rd_open;
  logic            r_wr_strobe;

  logic [ADDR_W:0] w_wr_ptr_inc;
  logic [ADDR_W:0] w_rd_ptr_inc;
  logic [ADDR_W:0] w_seek_ptr;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_accept;
  logic            w_rd_accept;

  // The write-open flag carries no meaning for pointer handling: a re-open
  // simply continues from wherever the pointers were left.
  logic            w_unused_w_open;
  assign w_unused_w_open = user_w_mem_open;

  // Flags decode straight from the pointer registers; in wrap mode the
  // pointer never reaches DEPTH, and the mode gate keeps them constant 0.
  assign w_full  = c_stop && (r_wr_ptr == c_ptr_end);
  assign w_empty = c_stop && (r_rd_ptr == c_ptr_end);

  assign w_wr_accept = user_w_mem_wren && !w_full;
  assign w_rd_accept = user_r_mem_rden && !w_empty;
  assign w_seek_ptr  = {1'b0, user_mem_addr};

  generate
    if (WRAP == MEM_MODE_WRAP) begin : g_wrap
      // Modulo-DEPTH increment: the low bits roll over, top bit pinned to 0.
      assign w_wr_ptr_inc = {1'b0, r_wr_ptr[ADDR_W-1:0] + c_one_a};
      assign w_rd_ptr_inc = {1'b0, r_rd_ptr[ADDR_W-1:0] + c_one_a};
    end else begin : g_stop
      // Plain increment; accept is blocked at DEPTH so this saturates there.
      assign w_wr_ptr_inc = r_wr_ptr + c_one_p;
      assign w_rd_ptr_inc = r_rd_ptr + c_one_p;
    end
  endgenerate

  // Pointer registers. A seek overrides any increment on the same edge; the
  // accompanying write/read still uses the old pointer as its RAM address.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wr_strobe <= 1'b0;
      r_rd_open   <= 1'b0;
    end else begin
      r_wr_strobe <= w_wr_accept;
      // Registered so eof never depends combinationally on an input.
      r_rd_open   <= user_r_mem_open;

      if (user_mem_addr_update) begin
        r_wr_ptr <= w_seek_ptr;
      end else if (w_wr_accept) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end

      if (user_mem_addr_update) begin
        r_rd_ptr <= w_seek_ptr;
      end else if (w_rd_accept) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  xillybus_mem_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (bus_clk),
    .rst_n   (bus_rst_n),
    .wr_en   (w_wr_accept),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (user_w_mem_data),
    .rd_en   (w_rd_accept),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (user_r_mem_data),
    .b_addr  (hw_rd_addr),
    .b_data  (hw_rd_data)
  );

  assign user_w_mem_full  = w_full;
  assign user_r_mem_empty = w_empty;
  assign user_r_mem_eof   = w_empty && r_rd_open;
  assign mem_wr_strobe    = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_xillybus_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_xillybus_mem_bridge
// Description : Self-checking bench for xillybus_mem_bridge. Two instances:
//               index 0 uses the defaults (8-bit, 32 deep, wrap), index 1 is
//               32-bit, 4 deep, stop-at-end. A reference model built from
//               plain arrays and integer pointers is compared against both
//               instances on every falling edge; directed sequences add
//               hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xillybus_mem_bridge;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]       wren, rden, upd, w_open, r_open;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0]  addr, hw_addr;

  wire [7:0]  a_rdata, a_hw;
  wire        a_full, a_empty, a_eof, a_strobe;
  wire [31:0] b_rdata, b_hw;
  wire        b_full, b_empty, b_eof, b_strobe;

  logic [1:0][31:0] o_rdata, o_hw;
  logic [1:0]       o_full, o_empty, o_eof, o_strobe;

  assign o_rdata[0] = {24'h0, a_rdata};
  assign o_rdata[1] = b_rdata;
  assign o_hw[0]    = {24'h0, a_hw};
  assign o_hw[1]    = b_hw;
  assign o_full     = {b_full, a_full};
  assign o_empty    = {b_empty, a_empty};
  assign o_eof      = {b_eof, a_eof};
  assign o_strobe   = {b_strobe, a_strobe};

  always #5 clk = ~clk;

  xillybus_mem_bridge dut_a (
    .bus_clk              (clk),
    .bus_rst_n            (rst_n),
    .user_w_mem_wren      (wren[0]),
    .user_w_mem_data      (wdata[0][7:0]),
    .user_w_mem_full      (a_full),
    .user_w_mem_open      (w_open[0]),
    .user_r_mem_rden      (rden[0]),
    .user_r_mem_data      (a_rdata),
    .user_r_mem_empty     (a_empty),
    .user_r_mem_eof       (a_eof),
    .user_r_mem_open      (r_open[0]),
    .user_mem_addr        (addr[0]),
    .user_mem_addr_update (upd[0]),
    .hw_rd_addr           (hw_addr[0]),
    .hw_rd_data           (a_hw),
    .mem_wr_strobe        (a_strobe)
  );

  xillybus_mem_bridge #(
    .DATA_W (32),
    .ADDR_W (2),
    .WRAP   (0)
  ) dut_b (
    .bus_clk              (clk),
    .bus_rst_n            (rst_n),
    .user_w_mem_wren      (wren[1]),
    .user_w_mem_data      (wdata[1]),
    .user_w_mem_full      (b_full),
    .user_w_mem_open      (w_open[1]),
    .user_r_mem_rden      (rden[1]),
    .user_r_mem_data      (b_rdata),
    .user_r_mem_empty     (b_empty),
    .user_r_mem_eof       (b_eof),
    .user_r_mem_open      (r_open[1]),
    .user_mem_addr        (addr[1][1:0]),
    .user_mem_addr_update (upd[1]),
    .hw_rd_addr           (hw_addr[1][1:0]),
    .hw_rd_data           (b_hw),
    .mem_wr_strobe        (b_strobe)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          depth [2] = '{32, 4};
  bit          wrapm [2] = '{1'b1, 1'b0};
  logic [31:0] dmask [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};

  int          m_wr [2];
  int          m_rd [2];
  logic [31:0] m_mem [2][32];
  bit          m_known [2][32];
  logic [31:0] m_rdata [2];
  logic [31:0] m_hw [2];
  bit          m_rd_ok [2];
  bit          m_hw_ok [2];
  bit          m_strobe [2];
  bit          m_open [2];

  function automatic bit m_full(input int i);
    return !wrapm[i] && (m_wr[i] == depth[i]);
  endfunction

  function automatic bit m_empty(input int i);
    return !wrapm[i] && (m_rd[i] == depth[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_wr[i] = 0;  m_rd[i] = 0;
        m_rdata[i] = 0; m_rd_ok[i] = 1'b1;
        m_hw[i] = 0;    m_hw_ok[i] = 1'b1;
        m_strobe[i] = 1'b0; m_open[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit wacc, racc;
        int ha;
        wacc = wren[i] && !m_full(i);
        racc = rden[i] && !m_empty(i);
        ha   = int'(hw_addr[i]);
        // Both reads observe the memory as it was before this edge's write.
        if (racc) begin
          m_rdata[i] = m_mem[i][m_rd[i]];
          m_rd_ok[i] = m_known[i][m_rd[i]];
        end
        m_hw[i]    = m_mem[i][ha];
        m_hw_ok[i] = m_known[i][ha];
        if (wacc) begin
          m_mem[i][m_wr[i]]   = wdata[i] & dmask[i];
          m_known[i][m_wr[i]] = 1'b1;
        end
        m_strobe[i] = wacc;
        m_open[i]   = r_open[i];
        if (upd[i]) begin
          m_wr[i] = int'(addr[i]);
          m_rd[i] = int'(addr[i]);
        end else begin
          if (wacc) m_wr[i] = wrapm[i] ? (m_wr[i] + 1) % depth[i] : m_wr[i] + 1;
          if (racc) m_rd[i] = wrapm[i] ? (m_rd[i] + 1) % depth[i] : m_rd[i] + 1;
        end
      end
    end
  end

  // Single compare process: every falling edge, both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_rd_ok[i]) chk("rdata", i, o_rdata[i], m_rdata[i]);
      if (m_hw_ok[i]) chk("hw_data", i, o_hw[i], m_hw[i]);
      chk("full",   i, 32'(o_full[i]),   32'(m_full(i)));
      chk("empty",  i, 32'(o_empty[i]),  32'(m_empty(i)));
      chk("eof",    i, 32'(o_eof[i]),    32'(m_empty(i) && m_open[i]));
      chk("strobe", i, 32'(o_strobe[i]), 32'(m_strobe[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wren = '0; rden = '0; upd = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic seek(input int i, input int a);
    upd[i] = 1'b1; addr[i] = 5'(a); cyc();
  endtask

  task automatic wr(input int i, input logic [31:0] d);
    wren[i] = 1'b1; wdata[i] = d; cyc();
  endtask

  task automatic rd(input int i);
    rden[i] = 1'b1; cyc();
  endtask

  task automatic hw(input int i, input int a);
    hw_addr[i] = 5'(a); cyc();
  endtask

  initial begin
    idle();
    wdata = '0; addr = '0; hw_addr = '0; w_open = '1; r_open = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_rdata",  0, o_rdata[0], 32'h0);
    chk("rst_strobe", 0, 32'(a_strobe), 32'h0);
    chk("rst_full",   1, 32'(b_full), 32'h0);
    chk("rst_empty",  1, 32'(b_empty), 32'h0);
    chk("rst_eof",    1, 32'(b_eof), 32'h0);

    // Fill both RAMs from pointer 0
    for (int k = 0; k < 32; k++) begin
      wren[0] = 1'b1; wdata[0] = 32'(k * 7 + 1);
      if (k < 4) begin wren[1] = 1'b1; wdata[1] = 32'h1000 + 32'(k); end
      cyc();
    end
    chk("fill_full", 1, 32'(b_full), 32'h1);
    chk("fill_wrap_full", 0, 32'(a_full), 32'h0);

    // Seek, write three, seek back, read three
    seek(0, 3);
    wr(0, 32'hA1); chk("t1_strobe", 0, 32'(a_strobe), 32'h1);
    wr(0, 32'hB2); chk("t1_strobe", 0, 32'(a_strobe), 32'h1);
    wr(0, 32'hC3); chk("t1_strobe", 0, 32'(a_strobe), 32'h1);
    cyc();         chk("t1_strobe_off", 0, 32'(a_strobe), 32'h0);
    seek(0, 3);
    rd(0); chk("t1_rd0", 0, o_rdata[0], 32'hA1);
    rd(0); chk("t1_rd1", 0, o_rdata[0], 32'hB2);
    rd(0); chk("t1_rd2", 0, o_rdata[0], 32'hC3);

    // Wrap from 31 to 0
    seek(0, 31);
    wr(0, 32'h11);
    wr(0, 32'h22);
    hw(0, 31); chk("t2_ram31", 0, o_hw[0], 32'h11);
    hw(0, 0);  chk("t2_ram0",  0, o_hw[0], 32'h22);
    chk("t2_full", 0, 32'(a_full), 32'h0);

    // Stop mode: fill, ignore extra write, read to end, eof, seek clears
    r_open[1] = 1'b1;
    seek(1, 2);
    chk("t3_seek_clr_full", 1, 32'(b_full), 32'h0);
    wr(1, 32'hDEAD_BEEF);
    wr(1, 32'h1234_5678);
    chk("t3_full", 1, 32'(b_full), 32'h1);
    wr(1, 32'hFFFF_FFFF);
    chk("t3_ignored_strobe", 1, 32'(b_strobe), 32'h0);
    hw(1, 0); chk("t3_ram0_kept", 1, o_hw[1], 32'h1000);
    seek(1, 2);
    chk("t3_full_cleared", 1, 32'(b_full), 32'h0);
    rd(1); chk("t3_rd0", 1, o_rdata[1], 32'hDEAD_BEEF);
    chk("t3_not_empty", 1, 32'(b_empty), 32'h0);
    rd(1); chk("t3_rd1", 1, o_rdata[1], 32'h1234_5678);
    chk("t3_empty", 1, 32'(b_empty), 32'h1);
    chk("t3_eof_open", 1, 32'(b_eof), 32'h1);
    rd(1); chk("t3_rd_hold", 1, o_rdata[1], 32'h1234_5678);
    r_open[1] = 1'b0; cyc();
    chk("t3_eof_closed", 1, 32'(b_eof), 32'h0);
    r_open[1] = 1'b1; cyc();
    chk("t3_eof_reopen", 1, 32'(b_eof), 32'h1);
    seek(1, 0);
    chk("t3_seek_empty", 1, 32'(b_empty), 32'h0);
    chk("t3_seek_eof",   1, 32'(b_eof), 32'h0);

    // Write coinciding with seek
    seek(0, 4);
    wren[0] = 1'b1; wdata[0] = 32'h44; upd[0] = 1'b1; addr[0] = 5'd7; cyc();
    wr(0, 32'h77);
    hw(0, 4); chk("t4_ram4", 0, o_hw[0], 32'h44);
    hw(0, 7); chk("t4_ram7", 0, o_hw[0], 32'h77);
    hw(0, 5); chk("t4_ram5", 0, o_hw[0], 32'hC3);

    // Side port collision then new value
    hw_addr[0] = 5'd9;
    seek(0, 9);
    wr(0, 32'h5A); chk("t5_collide_old", 0, o_hw[0], 32'h40);
    cyc();         chk("t5_new", 0, o_hw[0], 32'h5A);

    // Asynchronous reset mid-burst
    seek(0, 7);
    wr(0, 32'h71);
    wr(0, 32'h72);
    wr(0, 32'h73);
    wren[0] = 1'b1; wdata[0] = 32'hEE;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rdata", 0, o_rdata[0], 32'h0);
    chk("t6_hw",    0, o_hw[0], 32'h0);
    chk("t6_strobe", 0, 32'(a_strobe), 32'h0);
    chk("t6_rdata", 1, o_rdata[1], 32'h0);
    chk("t6_hw",    1, o_hw[1], 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 32'h99);
    seek(0, 7);
    rd(0); chk("t6_keep7", 0, o_rdata[0], 32'h71);
    rd(0); chk("t6_keep8", 0, o_rdata[0], 32'h72);
    rd(0); chk("t6_keep9", 0, o_rdata[0], 32'h73);
    hw(0, 0); chk("t6_ptr0", 0, o_hw[0], 32'h99);

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
